// File: rtl/uncached_write_buffer_pkg.sv
// Shared types for the uncached store buffer: queued entry layout, drain FSM states,
// and the fixed AXI encodings the buffer drives.
package uncached_write_buffer_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = DATA_W / 8;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [STRB_W-1:0] strb;
        logic [1:0]        size;
    } wb_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_AW,
        ST_W,
        ST_BR
    } wb_state_e;

endpackage

// File: rtl/uncached_write_buffer_wbuf_fifo.sv
// Circular store queue with head read port and word-address hazard lookup.
// Push lands in one cycle and is refused while full; pop is issued by the drain FSM.
module wbuf_fifo
    import uncached_write_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_push,
    input  wb_entry_t         i_entry,
    output logic              o_full,
    input  logic              i_pop,
    output wb_entry_t         o_head,
    output logic              o_nonempty,
    input  logic [ADDR_W-3:0] i_lk_word,
    output logic              o_lk_hit
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);

    wb_entry_t        r_mem [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [PTR_W:0]   r_count;
    logic             w_push;
    logic [DEPTH-1:0] w_match;

    assign o_full     = (r_count == CNT_FULL);
    assign o_nonempty = (r_count != '0);
    assign w_push     = i_push && !o_full;
    assign o_head     = r_mem[r_head];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_tail <= r_tail + PTR_W'(1);
            if (i_pop)  r_head <= r_head + PTR_W'(1);
            r_count <= r_count + (PTR_W+1)'(w_push) - (PTR_W+1)'(i_pop);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_tail] <= i_entry;
    end

    // A slot is live when its distance from head (mod DEPTH) is below count;
    // the in-flight head stays live until its B response pops it.
    always_comb begin
        w_match = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_match[i] = ({1'b0, PTR_W'(i) - r_head} < r_count) &&
                         (r_mem[i].addr[ADDR_W-1:2] == i_lk_word);
        end
    end

    assign o_lk_hit = |w_match;

endmodule

// File: rtl/uncached_write_buffer.sv
// Posted uncached-store buffer draining in order as single-beat AXI writes (AW, then W, then B).
// Stores accepted in one cycle while not full; AXI valids and payloads hold until ready.
module uncached_write_buffer
    import uncached_write_buffer_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter logic [3:0]  AXI_ID = 4'b0000
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic        st_valid,
    output logic        st_ready,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    input  logic [3:0]  st_strb,
    input  logic [1:0]  st_size,
    input  logic [31:0] lk_addr,
    output logic        lk_hit,
    output logic        empty,
    output logic        wr_err,
    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [3:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic [1:0]  awlock,
    output logic [3:0]  awcache,
    output logic [2:0]  awprot,
    output logic        awvalid,
    input  logic        awready,
    output logic [3:0]  wid,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,
    input  logic [3:0]  bid,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
);

    wb_state_e   r_state, w_state_nxt;
    wb_entry_t   w_head, w_st_entry;
    logic        w_full, w_nonempty, w_pop;

    logic        r_awvalid, w_awvalid_nxt;
    logic [31:0] r_awaddr,  w_awaddr_nxt;
    logic [2:0]  r_awsize,  w_awsize_nxt;
    logic        r_wvalid,  w_wvalid_nxt;
    logic [31:0] r_wdata,   w_wdata_nxt;
    logic [3:0]  r_wstrb,   w_wstrb_nxt;
    logic        r_wlast,   w_wlast_nxt;
    logic        r_wr_err,  w_wr_err_nxt;
    logic        w_unused;

    assign w_st_entry = '{addr: st_addr, data: st_data, strb: st_strb, size: st_size};
    assign w_unused   = ^{bid, lk_addr[1:0]};

    wbuf_fifo #(.DEPTH(DEPTH)) u_fifo (
        .i_clk      (aclk),
        .i_rst      (areset),
        .i_push     (st_valid),
        .i_entry    (w_st_entry),
        .o_full     (w_full),
        .i_pop      (w_pop),
        .o_head     (w_head),
        .o_nonempty (w_nonempty),
        .i_lk_word  (lk_addr[31:2]),
        .o_lk_hit   (lk_hit)
    );

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state   <= ST_IDLE;
            r_awvalid <= 1'b0;
            r_awaddr  <= '0;
            r_awsize  <= '0;
            r_wvalid  <= 1'b0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_wlast   <= 1'b0;
            r_wr_err  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_awvalid <= w_awvalid_nxt;
            r_awaddr  <= w_awaddr_nxt;
            r_awsize  <= w_awsize_nxt;
            r_wvalid  <= w_wvalid_nxt;
            r_wdata   <= w_wdata_nxt;
            r_wstrb   <= w_wstrb_nxt;
            r_wlast   <= w_wlast_nxt;
            r_wr_err  <= w_wr_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_awvalid_nxt = r_awvalid;
        w_awaddr_nxt  = r_awaddr;
        w_awsize_nxt  = r_awsize;
        w_wvalid_nxt  = r_wvalid;
        w_wdata_nxt   = r_wdata;
        w_wstrb_nxt   = r_wstrb;
        w_wlast_nxt   = r_wlast;
        w_wr_err_nxt  = 1'b0;
        w_pop         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_nonempty) begin
                    w_awvalid_nxt = 1'b1;
                    w_awaddr_nxt  = w_head.addr;
                    w_awsize_nxt  = {1'b0, w_head.size};
                    w_state_nxt   = ST_AW;
                end
            end
            ST_AW: begin
                if (awready) begin
                    w_awvalid_nxt = 1'b0;
                    w_wvalid_nxt  = 1'b1;
                    w_wlast_nxt   = 1'b1;
                    w_wdata_nxt   = w_head.data;
                    w_wstrb_nxt   = w_head.strb;
                    w_state_nxt   = ST_W;
                end
            end
            ST_W: begin
                if (wready) begin
                    w_wvalid_nxt = 1'b0;
                    w_wlast_nxt  = 1'b0;
                    w_state_nxt  = ST_BR;
                end
            end
            ST_BR: begin
                // Head is released only here, so lk_hit covers the store until it is acknowledged.
                if (bvalid) begin
                    w_pop        = 1'b1;
                    w_wr_err_nxt = (bresp != AXI_RESP_OKAY);
                    w_state_nxt  = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign st_ready = !w_full;
    assign empty    = !w_nonempty && (r_state == ST_IDLE);
    assign wr_err   = r_wr_err;

    assign awid    = AXI_ID;
    assign awaddr  = r_awaddr;
    assign awlen   = 4'd0;
    assign awsize  = r_awsize;
    assign awburst = AXI_BURST_INCR;
    assign awlock  = 2'b00;
    assign awcache = 4'd0;
    assign awprot  = 3'd0;
    assign awvalid = r_awvalid;
    assign wid     = AXI_ID;
    assign wdata   = r_wdata;
    assign wstrb   = r_wstrb;
    assign wlast   = r_wlast;
    assign wvalid  = r_wvalid;
    assign bready  = 1'b1;

endmodule

// File: tb/tb_uncached_write_buffer.sv
// Bench for uncached_write_buffer: directed sequences, a lookup vector table,
// and a randomized run against an in-order queue model of pending stores.
module tb_uncached_write_buffer;

    localparam int DEPTH = 4;

    logic        aclk = 1'b0;
    logic        areset;
    logic        st_valid, st_ready;
    logic [31:0] st_addr, st_data;
    logic [3:0]  st_strb;
    logic [1:0]  st_size;
    logic [31:0] lk_addr;
    logic        lk_hit, empty, wr_err;
    logic [3:0]  awid, awlen, awcache, wid, wstrb, bid;
    logic [31:0] awaddr, wdata;
    logic [2:0]  awsize, awprot;
    logic [1:0]  awburst, awlock, bresp;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

    always #5 aclk = ~aclk;

    uncached_write_buffer #(.DEPTH(DEPTH), .AXI_ID(4'b0000)) dut (
        .aclk(aclk), .areset(areset),
        .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr), .st_data(st_data),
        .st_strb(st_strb), .st_size(st_size),
        .lk_addr(lk_addr), .lk_hit(lk_hit), .empty(empty), .wr_err(wr_err),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [31:0] lk_addr;
        logic        exp_hit;
        logic        exp_st_ready;
    } lk_vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  size;
    } st_t;

    lk_vec_t lk_tbl [8];
    st_t     q [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        @(negedge aclk);
    endtask

    task automatic push_store(input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] s, input logic [1:0] z);
        st_valid = 1'b1; st_addr = a; st_data = d; st_strb = s; st_size = z;
        step();
        st_valid = 1'b0;
    endtask

    task automatic wait_awvalid(input string tag);
        int t = 0;
        while (!awvalid && t < 20) begin step(); t++; end
        check({tag, "_awvalid"}, awvalid, 1);
    endtask

    // Zero-wait drain of the head store, optionally pushing on the B cycle.
    task automatic drain_one(input string tag, input logic [31:0] ea, input logic [31:0] ed,
                             input logic [1:0] resp, input logic push_en,
                             input logic [31:0] pa, input logic [31:0] pd, input logic exp_rdy);
        awready = 1'b1;
        wait_awvalid(tag);
        check({tag, "_awaddr"}, awaddr, ea);
        step();
        awready = 1'b0; wready = 1'b1;
        check({tag, "_wvalid"}, wvalid, 1);
        check({tag, "_wdata"}, wdata, ed);
        check({tag, "_wlast"}, wlast, 1);
        step();
        wready = 1'b0;
        bvalid = 1'b1; bresp = resp;
        if (push_en) begin
            st_valid = 1'b1; st_addr = pa; st_data = pd; st_strb = 4'hF; st_size = 2'd2;
            #1;
            check({tag, "_push_rdy"}, st_ready, exp_rdy);
        end
        step();
        bvalid = 1'b0; bresp = 2'b00; st_valid = 1'b0;
        check({tag, "_wr_err"}, wr_err, resp != 2'b00);
    endtask

    initial begin
        logic        exp_hit, exp_err, w_wait, b_pend, push;
        logic        prev_aw_stall, prev_w_stall;
        logic [31:0] prev_awaddr, prev_wdata;
        st_t         e;

        lk_tbl[0] = '{32'h1FAF_0012, 1'b1, 1'b0};
        lk_tbl[1] = '{32'h1FAF_0014, 1'b0, 1'b0};
        lk_tbl[2] = '{32'h1FAF_0020, 1'b1, 1'b0};
        lk_tbl[3] = '{32'h1FAF_0043, 1'b1, 1'b0};
        lk_tbl[4] = '{32'h1FAF_0050, 1'b0, 1'b0};
        lk_tbl[5] = '{32'h2FAF_0010, 1'b0, 1'b0};
        lk_tbl[6] = '{32'h1FAF_0031, 1'b1, 1'b0};
        lk_tbl[7] = '{32'h1FAF_0000, 1'b0, 1'b0};

        areset = 1'b1; st_valid = 1'b0; st_addr = '0; st_data = '0; st_strb = '0; st_size = '0;
        lk_addr = '0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00; bid = '0;
        @(negedge aclk);
        step(); step();
        areset = 1'b0;
        #1;
        check("rst_awvalid", awvalid, 0);
        check("rst_wvalid", wvalid, 0);
        check("rst_awaddr", awaddr, 0);
        check("rst_awsize", awsize, 0);
        check("rst_wdata", wdata, 0);
        check("rst_wstrb", wstrb, 0);
        check("rst_wlast", wlast, 0);
        check("rst_wr_err", wr_err, 0);
        check("rst_bready", bready, 1);
        check("rst_st_ready", st_ready, 1);
        check("rst_empty", empty, 1);
        check("rst_lk_hit", lk_hit, 0);
        check("rst_awburst", awburst, 2'b01);

        // Single store through a zero-wait slave.
        push_store(32'h1FAF_0004, 32'hDEAD_BEEF, 4'hF, 2'd2);
        check("one_aw_not_yet", awvalid, 0);
        check("one_not_empty", empty, 0);
        awready = 1'b1; wready = 1'b1;
        step();
        check("one_awvalid", awvalid, 1);
        check("one_awaddr", awaddr, 32'h1FAF_0004);
        check("one_awsize", awsize, 3'b010);
        check("one_awlen", awlen, 0);
        step();
        check("one_wvalid", wvalid, 1);
        check("one_wdata", wdata, 32'hDEAD_BEEF);
        check("one_wlast", wlast, 1);
        check("one_aw_dropped", awvalid, 0);
        step();
        check("one_w_dropped", wvalid, 0);
        check("one_br_not_empty", empty, 0);
        awready = 1'b0; wready = 1'b0; bvalid = 1'b1;
        step();
        bvalid = 1'b0;
        check("one_empty", empty, 1);

        // Fill with the slave stalled; 5th push refused.
        for (int i = 0; i < 4; i++)
            push_store(32'h1FAF_0010 + 32'(i) * 32'h10, 32'hA000_0000 + 32'(i), 4'hF, 2'd2);
        check("fill_full", st_ready, 0);
        st_valid = 1'b1; st_addr = 32'h1FAF_0050; st_data = 32'hA000_0004;
        #1;
        check("fill_5th_rdy", st_ready, 0);
        step();
        st_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            lk_addr = lk_tbl[i].lk_addr;
            #1;
            check($sformatf("lk_tbl%0d_hit", i), lk_hit, lk_tbl[i].exp_hit);
            check($sformatf("lk_tbl%0d_rdy", i), st_ready, lk_tbl[i].exp_st_ready);
        end
        lk_addr = 32'h1FAF_0012;
        drain_one("fill0", 32'h1FAF_0010, 32'hA000_0000, 2'b00, 1'b1, 32'h1FAF_0060, 32'hA000_0006, 1'b0);
        #1;
        check("hazard_cleared", lk_hit, 0);
        check("fill_rdy_after_pop", st_ready, 1);
        for (int i = 1; i < 4; i++)
            drain_one($sformatf("fill%0d", i), 32'h1FAF_0010 + 32'(i) * 32'h10,
                      32'hA000_0000 + 32'(i), 2'b00, 1'b0, 32'h0, 32'h0, 1'b1);
        check("fill_refused_not_stored", empty, 1);

        // W stalled for 7 cycles: payload held, no new AW.
        push_store(32'h1FAF_0100, 32'h1234_5678, 4'h3, 2'd1);
        awready = 1'b1;
        wait_awvalid("stall");
        step();
        awready = 1'b0;
        for (int k = 0; k < 7; k++) begin
            check("stall_wvalid", wvalid, 1);
            check("stall_wdata", wdata, 32'h1234_5678);
            check("stall_wstrb", wstrb, 4'h3);
            check("stall_no_aw", awvalid, 0);
            step();
        end
        wready = 1'b1;
        step();
        wready = 1'b0; bvalid = 1'b1;
        step();
        bvalid = 1'b0;
        check("stall_empty", empty, 1);

        // Push on the B cycle at count 2; pointers wrap.
        push_store(32'h1FAF_0200, 32'hB000_0000, 4'hF, 2'd2);
        push_store(32'h1FAF_0210, 32'hB000_0001, 4'hF, 2'd2);
        drain_one("cnt2_a", 32'h1FAF_0200, 32'hB000_0000, 2'b00, 1'b1, 32'h1FAF_0220, 32'hB000_0002, 1'b1);
        drain_one("cnt2_b", 32'h1FAF_0210, 32'hB000_0001, 2'b00, 1'b0, 32'h0, 32'h0, 1'b1);
        drain_one("cnt2_c", 32'h1FAF_0220, 32'hB000_0002, 2'b00, 1'b0, 32'h0, 32'h0, 1'b1);
        check("cnt2_empty", empty, 1);

        // Error response then normal drain.
        push_store(32'h1FAF_0300, 32'hC000_0000, 4'hF, 2'd2);
        push_store(32'h1FAF_0304, 32'hC000_0001, 4'hF, 2'd2);
        drain_one("err", 32'h1FAF_0300, 32'hC000_0000, 2'b10, 1'b0, 32'h0, 32'h0, 1'b1);
        step();
        check("err_pulse_len", wr_err, 0);
        drain_one("err_next", 32'h1FAF_0304, 32'hC000_0001, 2'b00, 1'b0, 32'h0, 32'h0, 1'b1);

        // Reset while in W.
        push_store(32'h1FAF_0400, 32'hD000_0000, 4'hF, 2'd2);
        awready = 1'b1;
        wait_awvalid("rst_mid");
        step();
        awready = 1'b0;
        check("rst_mid_in_w", wvalid, 1);
        areset = 1'b1;
        step();
        areset = 1'b0;
        lk_addr = 32'h1FAF_0400;
        #1;
        check("rst_mid_wvalid", wvalid, 0);
        check("rst_mid_awvalid", awvalid, 0);
        check("rst_mid_empty", empty, 1);
        check("rst_mid_lk_hit", lk_hit, 0);
        step();

        // Randomized traffic against the queue model.
        exp_err = 1'b0; w_wait = 1'b0; b_pend = 1'b0;
        prev_aw_stall = 1'b0; prev_w_stall = 1'b0; prev_awaddr = '0; prev_wdata = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            st_valid = 1'($urandom_range(0, 1));
            st_addr  = 32'h1FAF_0000 + (32'($urandom_range(0, 15)) << 2) + 32'($urandom_range(0, 3));
            st_data  = $urandom;
            st_strb  = 4'($urandom_range(0, 15));
            st_size  = 2'($urandom_range(0, 2));
            if (q.size() != 0 && $urandom_range(0, 1) == 1) begin
                e = q[$urandom_range(0, q.size() - 1)];
                lk_addr = {e.addr[31:2], 2'($urandom_range(0, 3))};
            end else begin
                lk_addr = 32'h1FAF_0000 + 32'($urandom_range(0, 80));
            end
            awready = ($urandom_range(0, 3) != 0);
            wready  = ($urandom_range(0, 3) != 0);
            bvalid  = b_pend && ($urandom_range(0, 2) != 0);
            bresp   = ($urandom_range(0, 7) == 0) ? 2'b10 : 2'b00;
            #1;
            exp_hit = 1'b0;
            foreach (q[k]) if (q[k].addr[31:2] == lk_addr[31:2]) exp_hit = 1'b1;
            check("rnd_st_ready", st_ready, q.size() < DEPTH);
            check("rnd_empty", empty, q.size() == 0);
            check("rnd_lk_hit", lk_hit, exp_hit);
            check("rnd_wr_err", wr_err, exp_err);
            check("rnd_aw_excl", awvalid && (w_wait || b_pend), 0);
            if (prev_aw_stall) check("rnd_aw_hold", {awvalid, awaddr}, {1'b1, prev_awaddr});
            if (prev_w_stall)  check("rnd_w_hold", {wvalid, wdata}, {1'b1, prev_wdata});
            if (awvalid && awready) begin
                if (q.size() == 0) check("rnd_aw_spurious", awvalid, 0);
                else begin
                    check("rnd_awaddr", awaddr, q[0].addr);
                    check("rnd_awsize", awsize, {1'b0, q[0].size});
                    check("rnd_awlen", awlen, 0);
                end
                w_wait = 1'b1;
            end
            if (wvalid && wready) begin
                if (q.size() == 0) check("rnd_w_spurious", wvalid, 0);
                else begin
                    check("rnd_wdata", wdata, q[0].data);
                    check("rnd_wstrb", wstrb, q[0].strb);
                    check("rnd_wlast", wlast, 1);
                end
                w_wait = 1'b0;
                b_pend = 1'b1;
            end
            prev_aw_stall = awvalid && !awready; prev_awaddr = awaddr;
            prev_w_stall  = wvalid && !wready;   prev_wdata  = wdata;
            push = st_valid && (q.size() < DEPTH);
            exp_err = 1'b0;
            if (bvalid) begin
                if (q.size() != 0) void'(q.pop_front());
                b_pend  = 1'b0;
                exp_err = (bresp != 2'b00);
            end
            if (push) q.push_back('{st_addr, st_data, st_strb, st_size});
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
